pipelined_pair_mac: RTL and testbench
=====================================

# pipelined_pair_mac

Pipelined, parametrised pairwise multiply-and-sum engine with a streaming accumulator. It forms signed products of adjacent word pairs from a packed input vector and reduces them through a registered adder tree. It can accumulate successive results across samples. It sits in the datapath between sample framing and downstream filter/correlator logic, and supersedes the purely combinational pair-multiplier.

## Interface
Parameters:
- N_WORDS, 16, number of signed input words per sample (any value >= 1, need not be a power of 2)
- NB_DATA, 8, width of each input word (two's complement)
- NB_GUARD, 4, extra accumulator guard bits above the tree-sum width

Derived values:
- P = ceil(N_WORDS/2), number of tree terms
- D = $clog2(P), tree depth (0 when P = 1)
- NB_SUM = 2*NB_DATA + D
- NB_ACC = NB_SUM + NB_GUARD
- LAT = D + 2

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- i_data  in  N_WORDS*NB_DATA  packed words; word k = i_data[(k+1)*NB_DATA-1 -: NB_DATA]
- i_valid  in  1  sample qualifier
- i_acc_en  in  1  1 = add this sample's sum to the accumulator; 0 = load the sum
- i_acc_clr  in  1  1 = treat the accumulator as zero before this sample's operation
- o_data  out  NB_ACC  accumulator value, signed
- o_valid  out  1  one-cycle pulse per accepted sample
- o_ovf  out  1  qualified by o_valid; this sample's accumulate step exceeded the NB_ACC signed range

## Operation
- Terms:
  - term j = word(2j) * word(2j+1), signed, 2*NB_DATA bits, for each complete pair.
  - If N_WORDS is odd, the last term is word(N_WORDS-1) sign-extended to 2*NB_DATA bits.
  - N_WORDS = 1 gives a single sign-extended term.
- Tree:
  - Terms are padded with zero terms to a power of 2 and summed pairwise in D levels.
  - Each level widens by 1 bit with sign extension.
  - The final sum is NB_SUM bits and is exact, with no overflow possible.
- Pipeline:
  - The product stage is registered, then each tree level is registered, then the accumulator.
  - i_valid, i_acc_en and i_acc_clr travel as sideband bits alongside the data.
  - No stalls and no backpressure: a new sample may be presented every cycle.
- Accumulator, updated only when the sample arriving at the accumulator stage is valid:
  - base = 0 if acc_clr, else the current accumulator value.
  - next = base + sign-extended sum if acc_en, else the sign-extended sum.
- Invalid cycles (bubbles): the accumulator and o_data hold their value; o_valid = 0; o_ovf = 0.
- o_ovf = 1 when the exact result of base + sum falls outside [-2^(NB_ACC-1), 2^(NB_ACC-1)-1]. A load (acc_en = 0) never overflows.
- Reset values: o_data = 0, o_valid = 0, o_ovf = 0, all sideband valid bits = 0, accumulator = 0.
- Reset mid-operation: every in-flight sample is discarded, and no o_valid is produced for samples accepted before reset.
- A sample presented in the same cycle that reset is high is ignored.

## Timing
- A sample accepted at edge t (i_valid = 1) gives o_valid = 1 on the cycle following edge t+LAT-1, i.e. LAT cycles after it is presented.
- o_data and o_ovf for that sample appear in that same cycle.
- Back-to-back samples produce back-to-back o_valid pulses in input order.
- Accumulation is a single-cycle add at the final stage, so back-to-back accumulation has no hazard.
- i_acc_en and i_acc_clr are sampled in the same cycle as their i_data and i_valid.

## Configuration
- MAC_SAT_EN defined:
  - On overflow the accumulator saturates to 2^(NB_ACC-1)-1 (positive overflow) or -2^(NB_ACC-1) (negative overflow).
  - o_ovf = 1 for that sample.
- MAC_SAT_EN undefined:
  - The accumulator wraps modulo 2^NB_ACC.
  - o_ovf still flags the wrap.
- Latency and all other behaviour are identical in both builds.

## Test plan
- Odd count, pass-through term. Setup: N_WORDS=5, NB_DATA=8, NB_GUARD=0 (LAT=4). Stimulus: words [2,3,-4,5,7], acc_en=0, i_valid for 1 cycle. Response: exactly one o_valid pulse 4 cycles later, o_data=-7, o_ovf=0.
- Extreme values. Setup: N_WORDS=4. Stimulus: all words -128, acc_en=0. Response: o_data=32768, o_ovf=0.
- Accumulate overflow. Setup: N_WORDS=2, NB_GUARD=0 (NB_ACC=16). Stimulus: three back-to-back samples (127,127); first acc_clr=1, then acc_en=1. Response: o_data = 16129, 32258, then -17149 with o_ovf=1 (MAC_SAT_EN undefined) or 32767 with o_ovf=1 (MAC_SAT_EN defined).
- Streaming and bubbles. Setup: N_WORDS=1. Stimulus: 5 with acc_clr=1, then a bubble, then -3 with acc_en=1. Response: o_valid pulses separated by 1 idle cycle; o_data 5 then 2; o_data holds 5 during the gap.
- Reset mid-flight. Stimulus: with LAT=4, present 2 valid samples, then assert reset for 1 cycle. Response: no o_valid thereafter; o_data=0, o_ovf=0; the next sample after reset behaves as a fresh load.

Source files
------------

// File: rtl/pipelined_pair_mac.sv
// rtl/pipelined_pair_mac.sv - pipelined signed pair-product adder tree with streaming accumulator
// Optional MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module pipelined_pair_mac #(
  parameter int  N_WORDS  = 16,
  parameter int  NB_DATA  = 8,
  parameter int  NB_GUARD = 4,
  localparam int P        = (N_WORDS + 1) / 2,
  localparam int D        = $clog2(P),
  localparam int NB_SUM   = 2 * NB_DATA + D,
  localparam int NB_ACC   = NB_SUM + NB_GUARD
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_WORDS*NB_DATA-1:0] i_data,
  input  logic                       i_valid,
  input  logic                       i_acc_en,
  input  logic                       i_acc_clr,
  output logic [NB_ACC-1:0]          o_data,
  output logic                       o_valid,
  output logic                       o_ovf
);
  localparam int P2 = 1 << D;

  logic signed [NB_SUM-1:0] term_w [0:P2-1];
  logic signed [NB_SUM-1:0] lvl_d  [0:D][0:P2-1];
  logic signed [NB_SUM-1:0] lvl_q  [0:D][0:P2-1];
  logic [D:0]               vld_d, vld_q, en_d, en_q, clr_d, clr_q;
  logic signed [NB_ACC-1:0] acc_d, acc_q, base_w;
  logic signed [NB_ACC:0]   exact_w;
  logic                     valid_d, valid_q, ovf_d, ovf_q;

  // Terms are held at full tree width so every level adds without further extension.
  for (genvar k = 0; k < P2; k++) begin : g_term
    if (2 * k + 1 < N_WORDS) begin : g_pair
      logic signed [NB_DATA-1:0]   a_w, b_w;
      logic signed [2*NB_DATA-1:0] prod_w;
      assign a_w       = i_data[(2*k+1)*NB_DATA-1 -: NB_DATA];
      assign b_w       = i_data[(2*k+2)*NB_DATA-1 -: NB_DATA];
      assign prod_w    = a_w * b_w;
      assign term_w[k] = NB_SUM'(prod_w);
    end else if (2 * k < N_WORDS) begin : g_odd
      logic signed [NB_DATA-1:0] a_w;
      assign a_w       = i_data[(2*k+1)*NB_DATA-1 -: NB_DATA];
      assign term_w[k] = NB_SUM'(a_w);
    end else begin : g_pad
      assign term_w[k] = '0;
    end
  end

  always_comb begin
    lvl_d    = lvl_q;
    vld_d[0] = i_valid;
    en_d[0]  = i_acc_en;
    clr_d[0] = i_acc_clr;
    for (int k = 0; k < P2; k++) lvl_d[0][k] = term_w[k];
    for (int l = 1; l <= D; l++) begin
      vld_d[l] = vld_q[l-1];
      en_d[l]  = en_q[l-1];
      clr_d[l] = clr_q[l-1];
      for (int k = 0; k < (P2 >> l); k++)
        lvl_d[l][k] = lvl_q[l-1][2*k] + lvl_q[l-1][2*k+1];
    end
  end

  // One extra bit of headroom makes the overflow test a simple top-two-bit compare.
  always_comb begin
    base_w  = clr_q[D] ? '0 : acc_q;
    exact_w = (NB_ACC+1)'(base_w) + (NB_ACC+1)'(lvl_q[D][0]);
    acc_d   = acc_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    if (vld_q[D]) begin
      valid_d = 1'b1;
      if (en_q[D]) begin
        ovf_d = exact_w[NB_ACC] != exact_w[NB_ACC-1];
`ifdef MAC_SAT_EN
        acc_d = ovf_d ? {exact_w[NB_ACC], {(NB_ACC-1){~exact_w[NB_ACC]}}}
                      : exact_w[NB_ACC-1:0];
`else
        acc_d = exact_w[NB_ACC-1:0];
`endif
      end else begin
        acc_d = NB_ACC'(lvl_q[D][0]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int l = 0; l <= D; l++)
        for (int k = 0; k < P2; k++) lvl_q[l][k] <= '0;
      vld_q   <= '0;
      en_q    <= '0;
      clr_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      vld_q   <= vld_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_data  = acc_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_pair_mac.sv
// tb/tb_pipelined_pair_mac.sv - directed bench over four parameterisations of pipelined_pair_mac
// Honours MAC_SAT_EN for the accumulate-overflow expectation.
module tb_pipelined_pair_mac;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

`ifdef MAC_SAT_EN
  localparam int C_THIRD = 32767;
`else
  localparam int C_THIRD = -17149;
`endif

  // A: N=5, guard 0 (LAT 4, NB_ACC 18)
  logic [39:0] a_in;
  logic        a_vld, a_en, a_clr, a_valid, a_ovf;
  logic [17:0] a_out;
  // B: N=4, guard 4 (LAT 3, NB_ACC 21)
  logic [31:0] b_in;
  logic        b_vld, b_en, b_clr, b_valid, b_ovf;
  logic [20:0] b_out;
  // C: N=2, guard 0 (LAT 2, NB_ACC 16)
  logic [15:0] c_in;
  logic        c_vld, c_en, c_clr, c_valid, c_ovf;
  logic [15:0] c_out;
  // D: N=1, guard 4 (LAT 2, NB_ACC 20)
  logic [7:0]  d_in;
  logic        d_vld, d_en, d_clr, d_valid, d_ovf;
  logic [19:0] d_out;

  pipelined_pair_mac #(.N_WORDS(5), .NB_DATA(8), .NB_GUARD(0)) u_a (
    .clock(clock), .reset(reset), .i_data(a_in), .i_valid(a_vld), .i_acc_en(a_en),
    .i_acc_clr(a_clr), .o_data(a_out), .o_valid(a_valid), .o_ovf(a_ovf));
  pipelined_pair_mac #(.N_WORDS(4), .NB_DATA(8), .NB_GUARD(4)) u_b (
    .clock(clock), .reset(reset), .i_data(b_in), .i_valid(b_vld), .i_acc_en(b_en),
    .i_acc_clr(b_clr), .o_data(b_out), .o_valid(b_valid), .o_ovf(b_ovf));
  pipelined_pair_mac #(.N_WORDS(2), .NB_DATA(8), .NB_GUARD(0)) u_c (
    .clock(clock), .reset(reset), .i_data(c_in), .i_valid(c_vld), .i_acc_en(c_en),
    .i_acc_clr(c_clr), .o_data(c_out), .o_valid(c_valid), .o_ovf(c_ovf));
  pipelined_pair_mac #(.N_WORDS(1), .NB_DATA(8), .NB_GUARD(4)) u_d (
    .clock(clock), .reset(reset), .i_data(d_in), .i_valid(d_vld), .i_acc_en(d_en),
    .i_acc_clr(d_clr), .o_data(d_out), .o_valid(d_valid), .o_ovf(d_ovf));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  initial begin
    reset = 1'b1;
    a_in = '0; a_vld = 0; a_en = 0; a_clr = 0;
    b_in = '0; b_vld = 0; b_en = 0; b_clr = 0;
    c_in = '0; c_vld = 0; c_en = 0; c_clr = 0;
    d_in = '0; d_vld = 0; d_en = 0; d_clr = 0;
    repeat (2) @(negedge clock);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_data", $signed(a_out), 0);
    check("rst_a_ovf", a_ovf, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_c_data", $signed(c_out), 0);
    check("rst_d_valid", d_valid, 0);
    reset = 1'b0;

    // Odd word count: 2*3 + (-4)*5 + 7 = -7, one pulse after 4 cycles.
    a_in = {8'h07, 8'h05, 8'hFC, 8'h03, 8'h02}; a_vld = 1; a_en = 0; a_clr = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      a_vld = 0;
      check("odd_valid", a_valid, (k == 4) ? 1 : 0);
      if (k == 4) begin
        check("odd_data", $signed(a_out), -7);
        check("odd_ovf", a_ovf, 0);
      end
    end

    // Extreme values: 2 * (-128 * -128) = 32768.
    b_in = {4{8'h80}}; b_vld = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      b_vld = 0;
      check("ext_valid", b_valid, (k == 3) ? 1 : 0);
      if (k == 3) begin
        check("ext_data", $signed(b_out), 32768);
        check("ext_ovf", b_ovf, 0);
      end
    end

    // Back-to-back accumulate of 127*127 into a 16-bit accumulator.
    c_in = 16'h7F7F; c_vld = 1; c_clr = 1; c_en = 0;
    @(negedge clock);
    c_clr = 0; c_en = 1;
    @(negedge clock);
    check("acc1_valid", c_valid, 1);
    check("acc1_data", $signed(c_out), 16129);
    check("acc1_ovf", c_ovf, 0);
    @(negedge clock);
    c_vld = 0;
    check("acc2_valid", c_valid, 1);
    check("acc2_data", $signed(c_out), 32258);
    check("acc2_ovf", c_ovf, 0);
    @(negedge clock);
    check("acc3_valid", c_valid, 1);
    check("acc3_data", $signed(c_out), C_THIRD);
    check("acc3_ovf", c_ovf, 1);
    @(negedge clock);
    check("acc_idle_valid", c_valid, 0);
    check("acc_idle_ovf", c_ovf, 0);
    check("acc_idle_hold", $signed(c_out), C_THIRD);

    // Streaming with a bubble: 5 (clear), gap, -3 accumulated -> 2.
    d_in = 8'h05; d_vld = 1; d_clr = 1; d_en = 0;
    @(negedge clock);
    d_vld = 0; d_clr = 0;
    @(negedge clock);
    check("str1_valid", d_valid, 1);
    check("str1_data", $signed(d_out), 5);
    d_in = 8'hFD; d_vld = 1; d_en = 1;
    @(negedge clock);
    d_vld = 0;
    check("str_gap_valid", d_valid, 0);
    check("str_gap_hold", $signed(d_out), 5);
    @(negedge clock);
    check("str2_valid", d_valid, 1);
    check("str2_data", $signed(d_out), 2);
    check("str2_ovf", d_ovf, 0);

    // Reset with two samples in flight, plus a sample offered during reset.
    a_in = {5{8'h01}}; a_vld = 1; a_en = 0; a_clr = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; a_vld = 0;
    check("rmid_data", $signed(a_out), 0);
    check("rmid_ovf", a_ovf, 0);
    for (int k = 1; k <= 5; k++) begin
      check("rmid_no_valid", a_valid, 0);
      @(negedge clock);
    end
    // Accumulating onto a freshly cleared accumulator must give the bare sum.
    a_in = {8'h07, 8'h05, 8'hFC, 8'h03, 8'h02}; a_vld = 1; a_en = 1; a_clr = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      a_vld = 0;
      check("post_rst_valid", a_valid, (k == 4) ? 1 : 0);
      if (k == 4) check("post_rst_data", $signed(a_out), -7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
